counter_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the 4-bit flip-flop counter datapath. Accepts RUN/STEP/CLEAR/STOP commands

---
 rtl/counter_seq_ctrl_pkg.sv | 29 ++
 rtl/cnt_ctrl_len_trk.sv | 79 +++++++
 rtl/counter_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl_pkg
// Shared definitions for the counter sequencer: FSM state encodings,
// command op codes and stop-reason codes. Imported by counter_seq_ctrl and
// cnt_ctrl_len_trk.
// ---------------------------------------------------------------------------
package counter_seq_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CLR  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Command op codes carried on cmd_op
    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    // Stop reasons reported on stop_rsn
    localparam logic [1:0] RSN_LEN   = 2'b00;
    localparam logic [1:0] RSN_STOP  = 2'b01;
    localparam logic [1:0] RSN_MATCH = 2'b10;
    localparam logic [1:0] RSN_CLR   = 2'b11;

endpackage

// File: rtl/cnt_ctrl_len_trk.sv
// ---------------------------------------------------------------------------
// cnt_ctrl_len_trk
// Run-length tracker: a down-counter of ticks still to issue and an
// up-counter of ticks already issued in the current RUN/STEP.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : load remaining with load_val_i, zero ticks
//   load_val_i    : run length to load
//   dec_i         : one tick issued this cycle
//   clr_i         : zero both counters (highest priority)
//   remaining_o   : ticks still to issue
//   ticks_o       : ticks issued so far
//   last_o        : remaining == 1 (the next issued tick is the final one)
// ---------------------------------------------------------------------------
module cnt_ctrl_len_trk
    import counter_seq_ctrl_pkg::*;
#(
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [LW-1:0] load_val_i,
    input  logic          dec_i,
    input  logic          clr_i,
    output logic [LW-1:0] remaining_o,
    output logic [LW-1:0] ticks_o,
    output logic          last_o
);

    localparam logic [LW-1:0] ZERO_C = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_C  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] MAX_C  = {LW{1'b1}};

    logic [LW-1:0] remaining_q;
    logic [LW-1:0] remaining_d;
    logic [LW-1:0] ticks_q;
    logic [LW-1:0] ticks_d;

    // Next-state for both counters; remaining never wraps below zero and
    // ticks saturates as a safety net even though a run cannot exceed it.
    always_comb begin
        remaining_d = remaining_q;
        ticks_d     = ticks_q;
        if (clr_i) begin
            remaining_d = ZERO_C;
            ticks_d     = ZERO_C;
        end else if (load_i) begin
            remaining_d = load_val_i;
            ticks_d     = ZERO_C;
        end else if (dec_i && (remaining_q != ZERO_C)) begin
            remaining_d = remaining_q - ONE_C;
            if (ticks_q != MAX_C) begin
                ticks_d = ticks_q + ONE_C;
            end else begin
                ticks_d = ticks_q;
            end
        end else begin
            remaining_d = remaining_q;
            ticks_d     = ticks_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= ZERO_C;
            ticks_q     <= ZERO_C;
        end else begin
            remaining_q <= remaining_d;
            ticks_q     <= ticks_d;
        end
    end

    assign remaining_o = remaining_q;
    assign ticks_o     = ticks_q;
    assign last_o      = (remaining_q == ONE_C);

endmodule

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
// Command-driven sequencer for a CW-bit counter. Accepts CLEAR/RUN/STEP/STOP
// over a valid/ready handshake, drives the counter's enable and clear, and
// reports completion with a stop reason and the number of ticks issued.
// Optional feature: define CNT_CTRL_MATCH_EN to end a run early when the
// counter output q_in equals match_val.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_op, cmd_len      : op code and RUN length
//   hold                 : pause counting during RUN
//   q_in, match_val      : counter output and early-stop value
//   cnt_en, cnt_clr      : counter advance / clear for the next edge
//   busy, done           : not idle / one-cycle completion pulse
//   stop_rsn, ticks      : why the last operation ended / ticks it issued
//   cmd_err              : pulse after an illegal command was handshaken
// ---------------------------------------------------------------------------
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int CW = 4,
    parameter int LW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [LW-1:0] cmd_len,
    input  logic          hold,
    input  logic [CW-1:0] q_in,
    input  logic [CW-1:0] match_val,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic          busy,
    output logic          done,
    output logic [1:0]    stop_rsn,
    output logic [LW-1:0] ticks,
    output logic          cmd_err
);

    localparam logic [LW-1:0] ZERO_C = {LW{1'b0}};
    localparam logic [LW-1:0] ONE_C  = {{(LW-1){1'b0}}, 1'b1};

    state_e        state_q;
    state_e        state_d;
    logic [1:0]    stop_rsn_q;
    logic [1:0]    stop_rsn_d;
    logic          cmd_err_q;
    logic          cmd_err_d;

    logic          accept_s;
    logic          match_hit_s;
    logic          cnt_en_s;
    logic          load_s;
    logic [LW-1:0] load_val_s;
    logic          clr_s;
    logic [LW-1:0] remaining_s;
    logic [LW-1:0] ticks_s;
    logic          last_s;

`ifdef CNT_CTRL_MATCH_EN
    assign match_hit_s = (state_q == ST_RUN) && (q_in == match_val);
`else
    // Without the match feature the counter value is only observed, never used.
    logic unused_match_s;
    assign match_hit_s    = 1'b0;
    assign unused_match_s = ^{q_in, match_val};
`endif

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign accept_s  = cmd_valid && cmd_ready;

    // Next-state, tracker control and counter enable decode
    always_comb begin
        state_d    = state_q;
        stop_rsn_d = stop_rsn_q;
        cmd_err_d  = 1'b0;
        cnt_en_s   = 1'b0;
        load_s     = 1'b0;
        load_val_s = ZERO_C;
        clr_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        CMD_CLEAR: begin
                            state_d = ST_CLR;
                        end
                        CMD_RUN: begin
                            load_s     = 1'b1;
                            load_val_s = cmd_len;
                            if (cmd_len != ZERO_C) begin
                                state_d = ST_RUN;
                            end else begin
                                // Zero-length run completes without a tick
                                state_d    = ST_DONE;
                                stop_rsn_d = RSN_LEN;
                            end
                        end
                        CMD_STEP: begin
                            load_s     = 1'b1;
                            load_val_s = ONE_C;
                            state_d    = ST_RUN;
                        end
                        CMD_STOP: begin
                            cmd_err_d = 1'b1;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                clr_s      = 1'b1;
                state_d    = ST_DONE;
                stop_rsn_d = RSN_CLR;
            end
            ST_RUN: begin
                cnt_en_s = ~hold & ~match_hit_s;
                // Exit priority: MATCH, then length exhausted, then STOP
                if (match_hit_s) begin
                    state_d    = ST_DONE;
                    stop_rsn_d = RSN_MATCH;
                end else if (cnt_en_s && last_s) begin
                    state_d    = ST_DONE;
                    stop_rsn_d = RSN_LEN;
                end else if (remaining_s == ZERO_C) begin
                    // Unreachable by construction; recover instead of hanging
                    state_d    = ST_DONE;
                    stop_rsn_d = RSN_LEN;
                end else if (accept_s && (cmd_op == CMD_STOP)) begin
                    state_d    = ST_DONE;
                    stop_rsn_d = RSN_STOP;
                end else begin
                    state_d = ST_RUN;
                end
                if (accept_s && (cmd_op != CMD_STOP)) begin
                    cmd_err_d = 1'b1;
                end else begin
                    cmd_err_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, stop reason and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stop_rsn_q <= RSN_LEN;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_rsn_q <= stop_rsn_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    cnt_ctrl_len_trk #(
        .LW (LW)
    ) u_len_trk (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_s),
        .load_val_i  (load_val_s),
        .dec_i       (cnt_en_s),
        .clr_i       (clr_s),
        .remaining_o (remaining_s),
        .ticks_o     (ticks_s),
        .last_o      (last_s)
    );

    assign cnt_en   = cnt_en_s;
    assign cnt_clr  = (state_q == ST_CLR);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign stop_rsn = stop_rsn_q;
    assign ticks    = ticks_s;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
// Directed bench for counter_seq_ctrl with a behavioural 4-bit counter
// driving q_in. Inputs change on the falling edge; outputs are sampled 1ns
// later, so each observation belongs to the cycle ending at the next rise.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_len;
    logic       hold;
    logic [3:0] q_in;
    logic [3:0] match_val;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic [1:0] stop_rsn;
    logic [7:0] ticks;
    logic       cmd_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic both_seen = 1'b0;

    counter_seq_ctrl #(.CW(4), .LW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .hold      (hold),
        .q_in      (q_in),
        .match_val (match_val),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .stop_rsn  (stop_rsn),
        .ticks     (ticks),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    // Counter datapath model feeding q_in
    always @(posedge clk) begin
        if (reset || cnt_clr) q_in <= 4'd0;
        else if (cnt_en)      q_in <= q_in + 4'd1;
    end

    // Enable and clear must never coincide
    always @(posedge clk) begin
        if (cnt_en && cnt_clr) both_seen <= 1'b1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        #1;
        chk_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    endtask

    // Observe cycles N+1.. after an accepted command, optionally driving hold
    // and one extra command at cycle cmd_k; stops at done or after 31 cycles.
    task automatic watch(input logic [31:0] hold_mask, input int cmd_k, input logic [1:0] k_op,
                         output logic [31:0] en_m, output logic [31:0] clr_m,
                         output logic [31:0] err_m, output int done_k);
        en_m = 32'd0; clr_m = 32'd0; err_m = 32'd0; done_k = 0;
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            hold = hold_mask[k];
            if (k == cmd_k) begin
                cmd_valid = 1'b1;
                cmd_op    = k_op;
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            en_m[k]  = cnt_en;
            clr_m[k] = cnt_clr;
            err_m[k] = cmd_err;
            if (done) begin
                done_k = k;
                break;
            end
        end
        hold      = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic do_run(input string tag, input logic [1:0] op, input logic [7:0] len,
                          input logic [31:0] hold_mask, input int cmd_k, input logic [1:0] k_op,
                          input logic [31:0] x_en, input logic [31:0] x_clr, input logic [31:0] x_err,
                          input int x_done, input logic [1:0] x_rsn, input logic [7:0] x_ticks);
        logic [31:0] em, cm, erm;
        int dk;
        issue(op, len);
        watch(hold_mask, cmd_k, k_op, em, cm, erm, dk);
        chk_eq({tag, "_en"},    em, x_en);
        chk_eq({tag, "_clr"},   cm, x_clr);
        chk_eq({tag, "_err"},   erm, x_err);
        chk_eq({tag, "_done"},  32'(dk), 32'(x_done));
        chk_eq({tag, "_rsn"},   32'(stop_rsn), 32'(x_rsn));
        chk_eq({tag, "_ticks"}, 32'(ticks), 32'(x_ticks));
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 8'd0;
        hold = 1'b0; match_val = 4'hF;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_busy",  32'(busy),      32'd0);
        chk_eq("rst_ready", 32'(cmd_ready), 32'd1);
        chk_eq("rst_en",    32'(cnt_en),    32'd0);
        chk_eq("rst_clr",   32'(cnt_clr),   32'd0);
        chk_eq("rst_done",  32'(done),      32'd0);
        chk_eq("rst_err",   32'(cmd_err),   32'd0);
        chk_eq("rst_rsn",   32'(stop_rsn),  32'd0);
        chk_eq("rst_ticks", 32'(ticks),     32'd0);

        // RUN 5: enables N+1..N+5, done N+6
        do_run("run5", 2'b01, 8'd5, 32'h0, 0, 2'b00, 32'h3E, 32'h0, 32'h0, 6, 2'b00, 8'd5);
        // RUN 6 with hold in run cycles 2-3: enables 1,4..8, done 9
        do_run("hold6", 2'b01, 8'd6, 32'hC, 0, 2'b00, 32'h1F2, 32'h0, 32'h0, 9, 2'b00, 8'd6);
        // CLEAR: clear only in N+1, done N+2, ticks zeroed
        do_run("clear", 2'b00, 8'd0, 32'h0, 0, 2'b00, 32'h0, 32'h2, 32'h0, 2, 2'b11, 8'd0);

        // STOP in IDLE: error pulse in N+1 only, stays idle
        issue(2'b11, 8'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk_eq("idle_stop_err",   32'(cmd_err),   32'd1);
        chk_eq("idle_stop_busy",  32'(busy),      32'd0);
        chk_eq("idle_stop_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        #1;
        chk_eq("idle_stop_err_end", 32'(cmd_err), 32'd0);

        // RUN 20 with STOP on 4th enable cycle
        do_run("stop", 2'b01, 8'd20, 32'h0, 4, 2'b11, 32'h1E, 32'h0, 32'h0, 5, 2'b01, 8'd4);
        // RUN 0: straight to done, no enable
        do_run("len0", 2'b01, 8'd0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 1, 2'b00, 8'd0);
        // RUN 3 with a STEP during the run: error pulse, run unaffected
        do_run("badcmd", 2'b01, 8'd3, 32'h0, 2, 2'b10, 32'hE, 32'h0, 32'h8, 4, 2'b00, 8'd3);
        // STEP: same timing as RUN 1
        do_run("step", 2'b10, 8'd77, 32'h0, 0, 2'b00, 32'h2, 32'h0, 32'h0, 2, 2'b00, 8'd1);
        // Clear counter so q_in starts at 0 for the match run
        do_run("clear2", 2'b00, 8'd0, 32'h0, 0, 2'b00, 32'h0, 32'h2, 32'h0, 2, 2'b11, 8'd0);
        match_val = 4'd3;
`ifdef CNT_CTRL_MATCH_EN
        do_run("match", 2'b01, 8'd10, 32'h0, 0, 2'b00, 32'hE, 32'h0, 32'h0, 5, 2'b10, 8'd3);
`else
        do_run("nomatch", 2'b01, 8'd10, 32'h0, 0, 2'b00, 32'h7FE, 32'h0, 32'h0, 11, 2'b00, 8'd10);
`endif
        match_val = 4'hF;

        // Reset in the middle of a run aborts without done
        issue(2'b01, 8'd10);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("midrun_en", 32'(cnt_en), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("abort_busy",  32'(busy),      32'd0);
        chk_eq("abort_en",    32'(cnt_en),    32'd0);
        chk_eq("abort_done",  32'(done),      32'd0);
        chk_eq("abort_ready", 32'(cmd_ready), 32'd1);
        chk_eq("abort_rsn",   32'(stop_rsn),  32'd0);
        chk_eq("abort_ticks", 32'(ticks),     32'd0);
        chk_eq("abort_err",   32'(cmd_err),   32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (done || cnt_en) done_cnt++;
        end
        chk_eq("abort_quiet", 32'(done_cnt), 32'd0);
        chk_eq("en_clr_exclusive", 32'(both_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
